// File: rtl/spi_arbiter_pkg.sv
// Shared types and defaults for the SPI master arbiter.
package spi_arbiter_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESPOND   = 2'd3
  } state_t;

  // (base + offset) mod modulus, for offset in 1..modulus and base < modulus.
  function automatic int wrap_index(input int base, input int offset, input int modulus);
    int sum;
    sum = base + offset;
    return (sum >= modulus) ? sum - modulus : sum;
  endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin pick: first set request bit after last_grant, wrapping.
// Zero latency; grant_valid low when nothing is requested.
module round_robin_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  localparam int INDEX_WIDTH = $clog2(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic [INDEX_WIDTH-1:0]    last_grant,
  output logic [INDEX_WIDTH-1:0]    grant,
  output logic                      grant_valid
);

  logic [INDEX_WIDTH-1:0] candidate;

  // Walk from the farthest candidate down so the nearest one after last_grant wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    candidate   = '0;
    for (int i = NUM_REQUESTERS; i >= 1; i--) begin
      candidate = INDEX_WIDTH'(wrap_index(int'(last_grant), i, NUM_REQUESTERS));
      if (request[candidate]) begin
        grant       = candidate;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin share of one SPI master: start 1 cycle after request, response 1 cycle after master_done.
// Optional watchdog on the wait for master_done is built with SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int INDEX_WIDTH   = $clog2(NUM_REQUESTERS)
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [NUM_REQUESTERS-1:0]          request_valid,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] request_data,
  output logic [NUM_REQUESTERS-1:0]          request_ready,
  output logic [NUM_REQUESTERS-1:0]          response_valid,
  output logic [DATA_WIDTH-1:0]              response_data,
  output logic                               response_error,
  output logic                               master_enable,
  output logic [DATA_WIDTH-1:0]              master_tx_data,
  output logic [INDEX_WIDTH-1:0]             master_chip_select_index,
  input  logic                               master_done,
  input  logic [DATA_WIDTH-1:0]              master_rx_data
);

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_REQUESTERS - 1);

  state_t                    state;
  logic [INDEX_WIDTH-1:0]    last_grant;
  logic [INDEX_WIDTH-1:0]    arb_grant;
  logic                      arb_grant_valid;
  logic [NUM_REQUESTERS-1:0] arb_onehot;
  logic [NUM_REQUESTERS-1:0] cs_onehot;

  round_robin_arbiter #(
    .NUM_REQUESTERS(NUM_REQUESTERS)
  ) u_round_robin_arbiter (
    .request    (request_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_valid(arb_grant_valid)
  );

  assign arb_onehot = NUM_REQUESTERS'(1) << arb_grant;
  // The chip-select register doubles as the latched grant for the whole transfer.
  assign cs_onehot  = NUM_REQUESTERS'(1) << master_chip_select_index;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMER_WIDTH-1:0] timer;
  logic                   timer_expired;

  assign timer_expired = (timer == TIMER_LAST);
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign response_error = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                    <= IDLE;
      last_grant               <= LAST_INDEX;
      request_ready            <= '0;
      response_valid           <= '0;
      response_data            <= '0;
      master_enable            <= 1'b0;
      master_tx_data           <= '0;
      master_chip_select_index <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      response_error           <= 1'b0;
      timer                    <= '0;
`endif
    end else begin
      request_ready  <= '0;
      response_valid <= '0;
      master_enable  <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_grant_valid) begin
            master_chip_select_index <= arb_grant;
            master_tx_data           <= request_data[int'(arb_grant)*DATA_WIDTH +: DATA_WIDTH];
            request_ready            <= arb_onehot;
            master_enable            <= 1'b1;
            state                    <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef SPI_ARB_TIMEOUT_EN
          timer <= '0;
`endif
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (master_done) begin
            response_data  <= master_rx_data;
            response_valid <= cs_onehot;
            state          <= RESPOND;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (timer_expired) begin
            response_data  <= '0;
            response_error <= 1'b1;
            response_valid <= cs_onehot;
            state          <= RESPOND;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end
        RESPOND: begin
`ifdef SPI_ARB_TIMEOUT_EN
          response_error <= 1'b0;
`endif
          last_grant <= master_chip_select_index;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter with a stub SPI master.
module tb_spi_master_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] tx;
  } grant_t;

  typedef struct {
    logic [3:0]  onehot;
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  request_valid;
  logic [N*DW-1:0] request_data;
  logic [N-1:0]  request_ready;
  logic [N-1:0]  response_valid;
  logic [DW-1:0] response_data;
  logic          response_error;
  logic          master_enable;
  logic [DW-1:0] master_tx_data;
  logic [1:0]    master_chip_select_index;
  logic          master_done;
  logic [DW-1:0] master_rx_data;

  spi_master_arbiter #(
    .NUM_REQUESTERS(N),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .request_valid           (request_valid),
    .request_data            (request_data),
    .request_ready           (request_ready),
    .response_valid          (response_valid),
    .response_data           (response_data),
    .response_error          (response_error),
    .master_enable           (master_enable),
    .master_tx_data          (master_tx_data),
    .master_chip_select_index(master_chip_select_index),
    .master_done             (master_done),
    .master_rx_data          (master_rx_data)
  );

  always #5 clock = ~clock;

  grant_t exp_g[$];
  resp_t  exp_r[$];
  grant_t mg;
  resp_t  mr;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int grant_cnt = 0;
  int resp_cnt = 0;
  int en_cyc = 0;
  int resp_cyc = 0;

  logic [1:0]  cur_cs = '0;
  logic [31:0] cur_tx = '0;
  logic [3:0]  keep = '0;

  int          stub_delay = 3;
  logic        stub_mute = 1'b0;
  logic [31:0] stub_rx[4];
  int          spurious_req = 0;
  int          spurious_seen = 0;
  int          stub_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // Monitor: every grant/response the DUT presents must match the head of its queue.
  always @(negedge clock) begin
    if (reset_n && (request_ready != 0 || master_enable)) begin
      if (exp_g.size() == 0) begin
        chk("unexpected_grant", {master_enable, request_ready}, 0);
      end else begin
        mg = exp_g.pop_front();
        chk("request_ready", request_ready, 4'b0001 << mg.idx);
        chk("master_enable", master_enable, 1);
        chk("chip_select", master_chip_select_index, mg.idx);
        chk("tx_data", master_tx_data, mg.tx);
        cur_cs = mg.idx;
        cur_tx = mg.tx;
      end
      grant_cnt++;
      en_cyc = cyc;
    end
    if (reset_n && response_valid != 0) begin
      if (exp_r.size() == 0) begin
        chk("unexpected_response", response_valid, 0);
      end else begin
        mr = exp_r.pop_front();
        chk("response_valid", response_valid, mr.onehot);
        chk("response_data", response_data, mr.data);
        chk("response_error", response_error, mr.err);
      end
      resp_cnt++;
      resp_cyc = cyc;
    end
  end

  // Stub SPI master: done pulse stub_delay cycles after master_enable.
  initial begin
    master_done = 1'b0;
    master_rx_data = '0;
    forever begin
      @(negedge clock);
      master_done = 1'b0;
      if (!reset_n) begin
        stub_cnt = 0;
      end else if (spurious_req != spurious_seen) begin
        spurious_seen++;
        master_done = 1'b1;
        master_rx_data = 32'hDEADBEEF;
      end else if (master_enable && !stub_mute) begin
        stub_cnt = stub_delay;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          master_done = 1'b1;
          master_rx_data = stub_rx[cur_cs];
          chk("tx_stable", master_tx_data, cur_tx);
          chk("cs_stable", master_chip_select_index, cur_cs);
        end
      end
    end
  end

  // One cycle step; requesters drop request_valid once served unless kept.
  task automatic tick();
    @(negedge clock);
    request_valid = request_valid & ~(request_ready & ~keep);
  endtask

  task automatic wait_grants(input int target, input int budget, input string name);
    int t = 0;
    while (grant_cnt < target && t < budget) begin
      tick();
      t++;
    end
    chk(name, grant_cnt >= target, 1);
  endtask

  task automatic wait_resps(input int target, input int budget, input string name);
    int t = 0;
    while (resp_cnt < target && t < budget) begin
      tick();
      t++;
    end
    chk(name, resp_cnt >= target, 1);
  endtask

  task automatic do_reset();
    request_valid = '0;
    keep = '0;
    tick();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic set_lane(input int i, input logic [31:0] v);
    request_data[i*DW +: DW] = v;
  endtask

  task automatic push_g(input logic [1:0] idx, input logic [31:0] tx);
    exp_g.push_back('{idx: idx, tx: tx});
  endtask

  task automatic push_r(input logic [3:0] oh, input logic [31:0] data, input logic err);
    exp_r.push_back('{onehot: oh, data: data, err: err});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb;
    request_valid = '0;
    request_data = '0;
    for (int i = 0; i < 4; i++) stub_rx[i] = '0;

    // Reset state
    #12;
    chk("rst_request_ready", request_ready, 0);
    chk("rst_response_valid", response_valid, 0);
    chk("rst_response_data", response_data, 0);
    chk("rst_response_error", response_error, 0);
    chk("rst_master_enable", master_enable, 0);
    chk("rst_master_tx_data", master_tx_data, 0);
    chk("rst_chip_select", master_chip_select_index, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    // Single request from requester 2, 40-cycle transfer
    set_lane(2, 32'h12345678);
    stub_rx[2] = 32'hACDC1112;
    stub_delay = 40;
    push_g(2'd2, 32'h12345678);
    push_r(4'b0100, 32'hACDC1112, 1'b0);
    rb = resp_cnt;
    request_valid = 4'b0100;
    tick();
    chk("t1_ready_latency", request_ready, 4'b0100);
    wait_resps(rb + 1, 100, "t1_response_seen");
    chk("t1_response_timing", resp_cyc - en_cyc, 41);
    tick();
    tick();
    chk("t1_response_data_hold", response_data, 32'hACDC1112);
    chk("t1_response_valid_pulse", response_valid, 0);

    // All four continuously from reset: 0,1,2,3,0
    do_reset();
    set_lane(0, 32'h11111111);
    set_lane(1, 32'h22222222);
    set_lane(2, 32'h33333333);
    set_lane(3, 32'h44444444);
    stub_rx[0] = 32'hA0000000;
    stub_rx[1] = 32'hA1111111;
    stub_rx[2] = 32'hA2222222;
    stub_rx[3] = 32'hA3333333;
    stub_delay = 3;
    push_g(2'd0, 32'h11111111);
    push_g(2'd1, 32'h22222222);
    push_g(2'd2, 32'h33333333);
    push_g(2'd3, 32'h44444444);
    push_g(2'd0, 32'h11111111);
    push_r(4'b0001, 32'hA0000000, 1'b0);
    push_r(4'b0010, 32'hA1111111, 1'b0);
    push_r(4'b0100, 32'hA2222222, 1'b0);
    push_r(4'b1000, 32'hA3333333, 1'b0);
    push_r(4'b0001, 32'hA0000000, 1'b0);
    rb = resp_cnt;
    keep = 4'b1111;
    request_valid = 4'b1111;
    wait_grants(grant_cnt + 5, 200, "t2_five_grants");
    request_valid = '0;
    keep = '0;
    wait_resps(rb + 5, 100, "t2_five_responses");

    // Requester 1 withdraws while 1 and 3 pend after grant 0: next grant is 3
    do_reset();
    stub_delay = 10;
    push_g(2'd0, 32'h11111111);
    push_g(2'd3, 32'h44444444);
    push_r(4'b0001, 32'hA0000000, 1'b0);
    push_r(4'b1000, 32'hA3333333, 1'b0);
    rb = resp_cnt;
    request_valid = 4'b1011;
    wait_grants(grant_cnt + 1, 50, "t3_first_grant");
    request_valid[1] = 1'b0;
    wait_resps(rb + 2, 200, "t3_two_responses");

    // Spurious master_done in IDLE is ignored
    tick();
    rb = resp_cnt;
    spurious_req++;
    repeat (4) tick();
    chk("t4_spurious_no_response", resp_cnt, rb);
    chk("t4_spurious_valid_low", response_valid, 0);
    set_lane(1, 32'h0BADF00D);
    stub_rx[1] = 32'h5A5AA5A5;
    push_g(2'd1, 32'h0BADF00D);
    push_r(4'b0010, 32'h5A5AA5A5, 1'b0);
    request_valid = 4'b0010;
    tick();
    chk("t4_ready_latency", request_ready, 4'b0010);
    wait_resps(rb + 1, 100, "t4_response_seen");

    // Reset during WAIT_DONE, then requester 0 wins first
    set_lane(2, 32'hCAFEF00D);
    stub_delay = 50;
    push_g(2'd2, 32'hCAFEF00D);
    rb = resp_cnt;
    request_valid = 4'b0100;
    wait_grants(grant_cnt + 1, 50, "t5_grant");
    repeat (5) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_arst_tx_data", master_tx_data, 0);
    chk("t5_arst_chip_select", master_chip_select_index, 0);
    chk("t5_arst_response_data", response_data, 0);
    chk("t5_arst_outputs", {request_ready, response_valid, master_enable, response_error}, 0);
    request_valid = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    set_lane(0, 32'h0F0F0F0F);
    set_lane(3, 32'hF0F0F0F0);
    stub_rx[0] = 32'h13572468;
    stub_rx[3] = 32'h24681357;
    stub_delay = 3;
    push_g(2'd0, 32'h0F0F0F0F);
    push_g(2'd3, 32'hF0F0F0F0);
    push_r(4'b0001, 32'h13572468, 1'b0);
    push_r(4'b1000, 32'h24681357, 1'b0);
    request_valid = 4'b1001;
    wait_resps(rb + 2, 100, "t5_post_reset_responses");

    // Master never completes
    set_lane(0, 32'h77777777);
    stub_mute = 1'b1;
    push_g(2'd0, 32'h77777777);
    rb = resp_cnt;
    request_valid = 4'b0001;
`ifdef SPI_ARB_TIMEOUT_EN
    push_r(4'b0001, 32'h00000000, 1'b1);
    wait_resps(rb + 1, 100, "t6_timeout_response");
    chk("t6_timeout_timing", resp_cyc - en_cyc, 17);
    tick();
    chk("t6_error_cleared", response_error, 0);
`else
    wait_grants(grant_cnt + 1, 50, "t6_grant");
    repeat (40) tick();
    chk("t6_no_response", resp_cnt, rb);
    chk("t6_error_low", response_error, 0);
    do_reset();
`endif
    stub_mute = 1'b0;

    repeat (5) tick();
    chk("grant_queue_drained", exp_g.size(), 0);
    chk("response_queue_drained", exp_r.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one SPI master transaction engine between NUM_REQUESTERS independent requesters.
- Each requester owns one chip-select index.
- Grants are round-robin. The block issues one full-duplex transfer to the master, waits for completion, and returns the received word to the winning requester.
- Sits between the register/DMA clients and the SPI master core.

Parameters:
- NUM_REQUESTERS, 4, number of requesters (2..8).
- DATA_WIDTH, 32, transfer word width in bits.
- INDEX_WIDTH, $clog2(NUM_REQUESTERS), width of the grant/chip-select index (derived, not overridden).
- TIMEOUT_CYCLES, 4096, watchdog limit in clock cycles (used only with SPI_ARB_TIMEOUT_EN).

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- request_valid  input  NUM_REQUESTERS  per-requester transfer request; held until the matching request_ready.
- request_data  input  NUM_REQUESTERS*DATA_WIDTH  packed tx words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- request_ready  output  NUM_REQUESTERS  one-cycle accept pulse, one-hot.
- response_valid  output  NUM_REQUESTERS  one-cycle completion pulse, one-hot.
- response_data  output  DATA_WIDTH  rx word; valid with response_valid.
- response_error  output  1  timeout flag; valid with response_valid.
- master_enable  output  1  one-cycle start pulse to the SPI master.
- master_tx_data  output  DATA_WIDTH  word to shift out; stable from master_enable until master_done.
- master_chip_select_index  output  INDEX_WIDTH  chip select to drive; stable for the whole transfer.
- master_done  input  1  one-cycle pulse when the master finishes a transfer.
- master_rx_data  input  DATA_WIDTH  received word; valid with master_done.

Behaviour:
- All outputs are registered.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - last_grant = NUM_REQUESTERS-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESPOND.
- IDLE:
  - If any request_valid bit is set, select the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQUESTERS.
  - Latch grant, request_data[grant] and chip-select index; go to ISSUE.
  - If none is set, stay in IDLE.
- ISSUE (exactly 1 cycle): master_enable=1 and request_ready[grant]=1; go to WAIT_DONE.
- Latency: request_valid sampled high at edge k → request_ready and master_enable high in cycle k+1.
- WAIT_DONE:
  - On master_done, capture master_rx_data and go to RESPOND.
  - master_done seen in IDLE, ISSUE or RESPOND is ignored.
- RESPOND (exactly 1 cycle):
  - response_valid[grant]=1 with response_data.
  - Update last_grant to grant; go to IDLE.
- Response timing: response_valid rises 1 cycle after master_done.
- Minimum request-to-request spacing is 4 cycles plus the master transfer time.
- Fairness: a requester holding request_valid continuously is served within NUM_REQUESTERS grants.
- request_valid dropped before grant: that requester is simply not selected. Requests are sampled only in IDLE.
- Reset mid-transfer: the FSM returns to IDLE immediately and no response is issued. The master is reset by the same reset_n.
- response_data holds its last value between responses. response_error is 0 unless a timeout occurs.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
  - On reaching TIMEOUT_CYCLES without master_done, go to RESPOND with response_data=0 and response_error=1.
  - A master_done arriving afterwards is ignored until the next WAIT_DONE.
- Undefined:
  - No counter is built; WAIT_DONE waits indefinitely.
  - response_error is tied to 0.

Decomposition:
- Package spi_arbiter_pkg:
  - state enum (IDLE, ISSUE, WAIT_DONE, RESPOND);
  - default DATA_WIDTH and TIMEOUT_CYCLES localparams.
- Sub-module round_robin_arbiter (parameter NUM_REQUESTERS):
  - combinational priority rotate from last_grant;
  - outputs grant index plus a grant_valid flag.
  - The FSM and all registers stay in spi_master_arbiter.

Test Plan:
- Single request: NUM_REQUESTERS=4, requester 2 requests with tx 32'h12345678; stub master returns 32'hACDC1112 after 40 cycles → master_chip_select_index=2, master_tx_data=32'h12345678, response_valid=4'b0100, response_data=32'hACDC1112.
- All four requesters request simultaneously and continuously from reset → grant order 0,1,2,3,0; each request_ready is a one-cycle pulse.
- Requester 1 withdraws request_valid before its turn while requesters 1 and 3 are pending after grant 0 → the next grant is 3; requester 1 gets no ready or response.
- Spurious master_done pulse in IDLE → no response_valid, state stays IDLE; the following real transfer completes normally.
- reset_n asserted during WAIT_DONE → all outputs 0 asynchronously; after release, requester 0 wins first.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, the stub never pulses master_done → response_valid with response_error=1 and response_data=0, 17 cycles after master_enable; without the macro, the arbiter stays in WAIT_DONE and response_error stays 0.
